q2a03_dma_arbiter: RTL and testbench

//  Sequences OAM sprite DMA ($4014) and DMC sample DMA for the Q2A03 core.

---
 rtl/q2a03_pkg.sv | 45 ++++
 rtl/q2a03_dma_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_q2a03_dma_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/q2a03_pkg.sv
// Shared definitions for the Q2A03 DMA arbiter: sequencer state encoding,
// fixed bus addresses and the get/put cycle parity helpers.
package q2a03_pkg;

  // Sequencer states of the sprite/sample DMA engine.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HALT   = 3'd1,
    ALIGN  = 3'd2,
    GET    = 3'd3,
    PUT    = 3'd4,
    DDUMMY = 3'd5,
    DGET   = 3'd6
  } dma_state_t;

  // CPU write address that starts sprite DMA; write data is the source page.
  localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
  // Destination of every sprite DMA put cycle.
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

  // Cycle parity: reads happen on get cycles, writes on put cycles.
  localparam logic PARITY_GET = 1'b0;
  localparam logic PARITY_PUT = 1'b1;

  // Parity of the CPU cycle that follows a cycle of the given parity.
  function automatic logic next_parity(input logic parity);
    return (parity == PARITY_GET) ? PARITY_PUT : PARITY_GET;
  endfunction

  // True when the cycle after the current one is a put cycle.
  function automatic logic next_is_put(input logic parity);
    return (next_parity(parity) == PARITY_PUT);
  endfunction

  // States in which the DMA engine, not the CPU, drives the system bus.
  function automatic logic state_owns_bus(input dma_state_t st);
    logic owns;
    case (st)
      GET, PUT, DGET: owns = 1'b1;
      default:        owns = 1'b0;
    endcase
    return owns;
  endfunction

endpackage

// File: rtl/q2a03_dma_arbiter.sv
// Q2A03 DMA arbiter: sequences sprite (OAM) DMA and DMC sample fetches,
// stalls the CPU through cpu_ready and multiplexes the shared system bus.
// Every state change happens on cyc_en; dmc_ack is the only output that
// pulses for a single clock together with the cyc_en ending a DMC get.
module q2a03_dma_arbiter
  import q2a03_pkg::*;
(
  input  logic        G_clock,
  input  logic        G_reset,
  input  logic        cyc_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wr_data,
  input  logic        cpu_rdwr,
  output logic        cpu_ready,
  input  logic        dmc_req,
  input  logic [15:0] dmc_addr,
  output logic        dmc_ack,
  output logic [7:0]  dmc_data,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wr_data,
  output logic        bus_rdwr,
  input  logic [7:0]  bus_rd_data,
  output logic        dma_owner
);

  dma_state_t  state_q,     state_d;
  logic        parity_q,    parity_d;
  logic        oam_pend_q,  oam_pend_d;
  logic        dmc_pend_q,  dmc_pend_d;
  logic [7:0]  page_q,      page_d;
  logic [7:0]  oam_idx_q,   oam_idx_d;
  logic [7:0]  latch_q,     latch_d;
  logic [7:0]  dmc_data_q,  dmc_data_d;
  logic        cpu_ready_q, cpu_ready_d;
  logic        dma_owner_q, dma_owner_d;

  logic        dmc_ack_s;
  logic        oam_start_s;
  logic        any_pend_s;

  // The DMC get completes on the cyc_en that closes the DGET cycle.
  assign dmc_ack_s   = cyc_en & (state_q == DGET);
  // A CPU write to the sprite DMA register is only accepted while running.
  assign oam_start_s = (state_q == IDLE) & ~cpu_rdwr & (cpu_addr == OAMDMA_ADDR);
  assign any_pend_s  = oam_pend_q | dmc_pend_q;

  // Next-state, request capture and datapath updates, all gated by cyc_en.
  always_comb begin
    state_d     = state_q;
    parity_d    = parity_q;
    oam_pend_d  = oam_pend_q;
    dmc_pend_d  = dmc_pend_q;
    page_d      = page_q;
    oam_idx_d   = oam_idx_q;
    latch_d     = latch_q;
    dmc_data_d  = dmc_data_q;

    if (cyc_en) begin
      parity_d   = next_parity(parity_q);
      // The request is considered served on the same edge that acknowledges it.
      dmc_pend_d = dmc_req & ~dmc_ack_s;

      case (state_q)
        IDLE: begin
          if (oam_start_s) begin
            oam_pend_d = 1'b1;
            page_d     = cpu_wr_data;
          end else begin
            oam_pend_d = oam_pend_q;
          end
          // The CPU may only be halted on a read cycle; writes always pass.
          if (any_pend_s && cpu_rdwr) begin
            state_d = HALT;
          end else begin
            state_d = IDLE;
          end
        end

        HALT: begin
          if (dmc_pend_q) begin
            state_d = DDUMMY;
          end else if (next_is_put(parity_q)) begin
            state_d = ALIGN;
          end else begin
            state_d = GET;
          end
        end

        ALIGN: begin
          if (dmc_pend_q) begin
            state_d = DGET;
          end else if (oam_pend_q) begin
            state_d = GET;
          end else begin
            state_d = IDLE;
          end
        end

        GET: begin
          latch_d = bus_rd_data;
          state_d = PUT;
        end

        PUT: begin
          oam_idx_d = oam_idx_q + 8'd1;
          if (oam_idx_q == 8'hFF) begin
            // Last byte of the page written: the sprite transfer is done.
            oam_pend_d = 1'b0;
            state_d    = dmc_pend_q ? DGET : IDLE;
          end else if (dmc_pend_q) begin
            state_d = DGET;
          end else begin
            state_d = GET;
          end
        end

        DDUMMY: begin
          if (next_is_put(parity_q)) begin
            state_d = ALIGN;
          end else begin
            state_d = DGET;
          end
        end

        DGET: begin
          dmc_data_d = bus_rd_data;
          state_d    = oam_pend_q ? ALIGN : IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    cpu_ready_d = (state_d == IDLE);
    dma_owner_d = state_owns_bus(state_d);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge G_clock or negedge G_reset) begin
    if (!G_reset) begin
      state_q     <= IDLE;
      parity_q    <= PARITY_GET;
      oam_pend_q  <= 1'b0;
      dmc_pend_q  <= 1'b0;
      page_q      <= 8'h00;
      oam_idx_q   <= 8'h00;
      latch_q     <= 8'h00;
      dmc_data_q  <= 8'h00;
      cpu_ready_q <= 1'b1;
      dma_owner_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      parity_q    <= parity_d;
      oam_pend_q  <= oam_pend_d;
      dmc_pend_q  <= dmc_pend_d;
      page_q      <= page_d;
      oam_idx_q   <= oam_idx_d;
      latch_q     <= latch_d;
      dmc_data_q  <= dmc_data_d;
      cpu_ready_q <= cpu_ready_d;
      dma_owner_q <= dma_owner_d;
    end
  end

  // System bus multiplexer: CPU passes straight through unless DMA owns it.
  always_comb begin
    bus_addr    = cpu_addr;
    bus_wr_data = cpu_wr_data;
    bus_rdwr    = cpu_rdwr;
    if (dma_owner_q) begin
      case (state_q)
        GET: begin
          bus_addr = {page_q, oam_idx_q};
          bus_rdwr = 1'b1;
        end
        PUT: begin
          bus_addr    = OAMDATA_ADDR;
          bus_wr_data = latch_q;
          bus_rdwr    = 1'b0;
        end
        DGET: begin
          bus_addr = dmc_addr;
          bus_rdwr = 1'b1;
        end
        default: begin
          bus_addr = cpu_addr;
        end
      endcase
    end else begin
      bus_addr = cpu_addr;
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign dma_owner = dma_owner_q;
  assign dmc_ack   = dmc_ack_s;
  // The fetched byte is forwarded during the acknowledge clock itself.
  assign dmc_data  = dmc_ack_s ? bus_rd_data : dmc_data_q;

endmodule

// File: tb/tb_q2a03_dma_arbiter.sv
// Self-checking bench for q2a03_dma_arbiter: a cycle-level CPU model issues
// reads/writes, randomised scenarios start OAM and DMC transfers, and the
// observed DMA bus trace, stall length and DMC handshake are compared with
// expectations derived from the transfer rules.
module tb_q2a03_dma_arbiter;

  logic        G_clock = 1'b0;
  logic        G_reset = 1'b1;
  logic        cyc_en = 1'b0;
  logic [15:0] cpu_addr = 16'h8000;
  logic [7:0]  cpu_wr_data = 8'h00;
  logic        cpu_rdwr = 1'b1;
  logic        cpu_ready;
  logic        dmc_req = 1'b0;
  logic [15:0] dmc_addr = 16'hC000;
  logic        dmc_ack;
  logic [7:0]  dmc_data;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wr_data;
  logic        bus_rdwr;
  logic [7:0]  bus_rd_data;
  logic        dma_owner;

  int checks = 0;
  int failures = 0;

  q2a03_dma_arbiter dut (
    .G_clock     (G_clock),
    .G_reset     (G_reset),
    .cyc_en      (cyc_en),
    .cpu_addr    (cpu_addr),
    .cpu_wr_data (cpu_wr_data),
    .cpu_rdwr    (cpu_rdwr),
    .cpu_ready   (cpu_ready),
    .dmc_req     (dmc_req),
    .dmc_addr    (dmc_addr),
    .dmc_ack     (dmc_ack),
    .dmc_data    (dmc_data),
    .bus_addr    (bus_addr),
    .bus_wr_data (bus_wr_data),
    .bus_rdwr    (bus_rdwr),
    .bus_rd_data (bus_rd_data),
    .dma_owner   (dma_owner)
  );

  always #5 G_clock = ~G_clock;

  // Memory contents seen on the system bus; C000 holds the sample byte 5A.
  function automatic logic [7:0] mem_f(input logic [15:0] a);
    if (a == 16'hC000) return 8'h5A;
    return a[7:0] ^ {a[14:8], a[15]} ^ 8'h96;
  endfunction

  assign bus_rd_data = mem_f(bus_addr);

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] addr;
    logic        rdwr;
    logic [7:0]  data;
  } cpu_op_t;

  cpu_op_t     cpu_q[$];
  logic [24:0] trace[$];
  int          cyc_n = 0;
  logic        s_ready, s_own, s_rdwr, s_ack;
  logic [15:0] s_addr;
  logic [7:0]  s_wd, s_dd;
  int          ack_cnt = 0;
  logic [7:0]  ack_data = 8'h00;
  int          arm_idx = -1;
  logic [7:0]  arm_page = 8'h00;
  logic        rst_at_40 = 1'b0;
  logic        rst_hit = 1'b0;

  // One CPU cycle: drive the CPU op, pulse cyc_en, sample outputs before the edge.
  task automatic do_cycle();
    cpu_op_t op;
    int gap;
    if (cpu_q.size() == 0) begin
      op.addr = 16'h8000 + 16'($urandom_range(0, 255));
      op.rdwr = 1'b1;
      op.data = 8'h00;
      cpu_q.push_back(op);
    end
    op = cpu_q[0];
    cpu_addr    = op.addr;
    cpu_rdwr    = op.rdwr;
    cpu_wr_data = op.data;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      @(negedge G_clock);
      cyc_en = 1'b0;
    end
    @(negedge G_clock);
    cyc_en = 1'b1;
    #1;
    s_ready = cpu_ready;
    s_own   = dma_owner;
    s_addr  = bus_addr;
    s_rdwr  = bus_rdwr;
    s_wd    = bus_wr_data;
    s_ack   = dmc_ack;
    s_dd    = dmc_data;
    if (s_own) begin
      trace.push_back({s_addr, s_rdwr, (s_rdwr ? 8'h00 : s_wd)});
    end else begin
      check_eq("mux_addr", 32'(s_addr), 32'(cpu_addr));
      check_eq("mux_rdwr", 32'(s_rdwr), 32'(cpu_rdwr));
      check_eq("mux_wdata", 32'(s_wd), 32'(cpu_wr_data));
    end
    if (s_ack) begin
      ack_cnt++;
      ack_data = s_dd;
    end
    if (arm_idx >= 0 && s_own && s_rdwr && s_addr == {arm_page, 8'(arm_idx)}) begin
      dmc_req = 1'b1;
      arm_idx = -1;
    end
    if (rst_at_40 && s_own && s_rdwr && s_addr[7:0] == 8'h40) begin
      G_reset = 1'b0;
      #1;
      check_eq("rst_cpu_ready", 32'(cpu_ready), 32'd1);
      check_eq("rst_dma_owner", 32'(dma_owner), 32'd0);
      check_eq("rst_dmc_ack", 32'(dmc_ack), 32'd0);
      rst_hit   = 1'b1;
      rst_at_40 = 1'b0;
    end
    @(posedge G_clock);
    #1;
    if (s_ready) void'(cpu_q.pop_front());
    if (s_ack) dmc_req = 1'b0;
    cyc_n++;
  endtask

  // kind: 0 OAM only, 1 OAM with DMC during GET of dmc_idx,
  //       2 OAM and DMC requested together, 3 DMC alone.
  task automatic run_scn(input int kind, input logic [7:0] page, input int wr_par,
                         input int n_wr, input int dmc_idx, input logic [15:0] daddr);
    cpu_op_t     op;
    logic [24:0] exp_tr[$];
    int          n_w, h, exp_stall, stall, first0, post, cnt, f0;
    trace.delete();
    cpu_q.delete();
    ack_cnt  = 0;
    dmc_addr = daddr;
    while ((cyc_n % 2) != wr_par) do_cycle();
    n_w = cyc_n;
    if (kind == 3) begin
      op.addr = 16'h8100; op.rdwr = 1'b1; op.data = 8'h00;
    end else begin
      op.addr = 16'h4014; op.rdwr = 1'b0; op.data = page;
    end
    cpu_q.push_back(op);
    for (int i = 0; i < n_wr; i++) begin
      op.addr = 16'h0300 + 16'(i); op.rdwr = 1'b0; op.data = 8'(8'hE0 + i);
      cpu_q.push_back(op);
    end
    for (int i = 0; i < 4; i++) begin
      op.addr = 16'h8200 + 16'(i); op.rdwr = 1'b1; op.data = 8'h00;
      cpu_q.push_back(op);
    end
    if (kind == 2 || kind == 3) dmc_req = 1'b1;
    if (kind == 1) begin
      arm_idx  = dmc_idx;
      arm_page = page;
    end

    // Expected halt cycle, stall length and DMA bus trace.
    h = (kind == 3) ? n_w + 2 : n_w + n_wr + 2;
    case (kind)
      0:       exp_stall = 513 + ((h % 2 == 0) ? 1 : 0);
      1:       exp_stall = 513 + ((h % 2 == 0) ? 1 : 0) + ((dmc_idx == 255) ? 1 : 2);
      2:       exp_stall = 516 + ((h % 2 == 1) ? 1 : 0);
      default: exp_stall = 3 + ((h % 2 == 1) ? 1 : 0);
    endcase
    if (kind == 2 || kind == 3) exp_tr.push_back({daddr, 1'b1, 8'h00});
    if (kind != 3) begin
      for (int i = 0; i < 256; i++) begin
        exp_tr.push_back({page, 8'(i), 1'b1, 8'h00});
        exp_tr.push_back({16'h2004, 1'b0, mem_f({page, 8'(i)})});
        if (kind == 1 && i == dmc_idx) exp_tr.push_back({daddr, 1'b1, 8'h00});
      end
    end

    stall = 0; first0 = -1; post = 0; cnt = 0;
    while (cnt < 900 && post < 4) begin
      do_cycle();
      if (!s_ready) begin
        stall++;
        if (first0 < 0) first0 = cyc_n - 1;
      end else if (first0 >= 0) begin
        post++;
      end
      cnt++;
    end
    arm_idx = -1;
    check_eq("scn_complete", 32'(post >= 4), 32'd1);
    check_eq("halt_start", 32'(first0), 32'(h));
    check_eq("stall_len", 32'(stall), 32'(exp_stall));
    check_eq("dmc_acks", 32'(ack_cnt), (kind == 0) ? 32'd0 : 32'd1);
    if (kind != 0) begin
      check_eq("dmc_data_ack", 32'(ack_data), 32'(mem_f(daddr)));
      check_eq("dmc_data_hold", 32'(dmc_data), 32'(mem_f(daddr)));
    end
    check_eq("trace_len", 32'(trace.size()), 32'(exp_tr.size()));
    for (int j = 0; j < exp_tr.size() && j < trace.size(); j++) begin
      f0 = failures;
      check_eq($sformatf("trace_%0d", j), 32'(trace[j]), 32'(exp_tr[j]));
      if (failures != f0) break;
    end
  endtask

  initial begin
    int own_cnt, stall_cnt, kind;
    cpu_op_t op;
    #2 G_reset = 1'b0;
    repeat (3) @(negedge G_clock);
    check_eq("reset_cpu_ready", 32'(cpu_ready), 32'd1);
    check_eq("reset_dma_owner", 32'(dma_owner), 32'd0);
    check_eq("reset_dmc_ack", 32'(dmc_ack), 32'd0);
    check_eq("reset_dmc_data", 32'(dmc_data), 32'h00);
    check_eq("reset_bus_addr", 32'(bus_addr), 32'(cpu_addr));
    G_reset = 1'b1;
    cyc_n = 0;

    // Reset in the middle of a sprite transfer.
    op.addr = 16'h4014; op.rdwr = 1'b0; op.data = 8'h03;
    cpu_q.push_back(op);
    rst_at_40 = 1'b1;
    for (int i = 0; i < 400 && !rst_hit; i++) do_cycle();
    check_eq("rst_mid_reached", 32'(rst_hit), 32'd1);
    rst_at_40 = 1'b0;
    @(negedge G_clock);
    cyc_en = 1'b0;
    repeat (2) @(negedge G_clock);
    G_reset = 1'b1;
    cyc_n = 0;
    cpu_q.delete();
    dmc_req = 1'b0;
    trace.delete();
    own_cnt = 0; stall_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      do_cycle();
      if (s_own) own_cnt++;
      if (!s_ready) stall_cnt++;
    end
    check_eq("post_rst_owner", 32'(own_cnt), 32'd0);
    check_eq("post_rst_stall", 32'(stall_cnt), 32'd0);

    // Directed scenarios.
    run_scn(0, 8'h02, 0, 0, -1, 16'hC000);   // write on get cycle: 514
    run_scn(0, 8'h02, 1, 0, -1, 16'hC000);   // write on put cycle: 513
    run_scn(0, 8'h05, 0, 2, -1, 16'hC000);   // two CPU writes defer the halt
    run_scn(1, 8'h02, 0, 0, 10, 16'hC000);   // DMC at index 10
    run_scn(2, 8'h07, 0, 0, -1, 16'hC000);   // simultaneous, both parities
    run_scn(2, 8'h07, 1, 1, -1, 16'hC123);
    run_scn(3, 8'h00, 0, 0, -1, 16'hC000);   // DMC alone, both parities
    run_scn(3, 8'h00, 1, 0, -1, 16'hD456);
    run_scn(1, 8'h11, 1, 0, 255, 16'hE000);  // DMC at the final byte

    // Randomised scenarios.
    for (int s = 0; s < 6; s++) begin
      kind = $urandom_range(0, 3);
      run_scn(kind, 8'($urandom_range(0, 8'hBF)), $urandom_range(0, 1),
              (kind == 3) ? 0 : $urandom_range(0, 2), $urandom_range(0, 255),
              16'hC000 | 16'($urandom_range(0, 16'h3FFF)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
